// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings and widths for the memory stage
package mem_stage_pkg;

  localparam int REG_IDX_W = 4;
  localparam int TIMER_W   = 8;

  typedef enum logic [0:0] {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  function automatic logic is_mem_op(input logic valid, input logic rd, input logic wr);
    return valid & (rd | wr);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - execute-side, data-memory, forwarding and write-back signals of the memory stage
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 16
);
  logic                 ex_valid;
  logic [DATA_W-1:0]    ex_alu_result;
  logic [DATA_W-1:0]    ex_store_data;
  logic                 ex_mem_read;
  logic                 ex_mem_write;
  logic                 ex_reg_write;
  logic                 ex_halt;
  logic [REG_IDX_W-1:0] ex_dst_reg;

  logic                 mem_stall;

  logic                 dmem_req;
  logic                 dmem_we;
  logic [DATA_W-1:0]    dmem_addr;
  logic [DATA_W-1:0]    dmem_wdata;
  logic [DATA_W-1:0]    dmem_rdata;
  logic                 dmem_ack;

  logic                 fwd_valid;
  logic [REG_IDX_W-1:0] fwd_dst;
  logic [DATA_W-1:0]    fwd_data;

  logic                 wb_valid;
  logic                 wb_reg_write;
  logic                 wb_halt;
  logic [REG_IDX_W-1:0] wb_dst_reg;
  logic [DATA_W-1:0]    wb_data;

  logic                 mem_err;

  // master: the memory stage itself (it masters the data-memory bus)
  modport master (
    input  ex_valid, ex_alu_result, ex_store_data, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_halt, ex_dst_reg, dmem_rdata, dmem_ack,
    output mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           fwd_valid, fwd_dst, fwd_data,
           wb_valid, wb_reg_write, wb_halt, wb_dst_reg, wb_data, mem_err
  );

  modport slave (
    output ex_valid, ex_alu_result, ex_store_data, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_halt, ex_dst_reg, dmem_rdata, dmem_ack,
    input  mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           fwd_valid, fwd_dst, fwd_data,
           wb_valid, wb_reg_write, wb_halt, wb_dst_reg, wb_data, mem_err
  );

endinterface

// File: rtl/mem_stage_ack_timer.sv
// rtl/mem_stage_ack_timer.sv - wait-cycle counter that flags an access stuck past the ack timeout
module mem_ack_timer
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TIMER_W-1:0] LAST_CNT = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] r_count;

  // r_count equals the number of wait cycles already spent, so the TIMEOUT-th one expires
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST_CNT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable & (r_count == LAST_CNT);

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX/MEM and MEM/WB registers with the data-memory handshake of the 16-bit core
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_stage_if.master bus
);

  logic                 r_m_valid;
  logic                 r_m_rd;
  logic                 r_m_wr;
  logic                 r_m_rw;
  logic                 r_m_halt;
  logic [DATA_W-1:0]    r_m_alu;
  logic [DATA_W-1:0]    r_m_sd;
  logic [REG_IDX_W-1:0] r_m_dst;

  logic                 r_wb_valid;
  logic                 r_wb_rw;
  logic                 r_wb_halt;
  logic [REG_IDX_W-1:0] r_wb_dst;
  logic [DATA_W-1:0]    r_wb_data;
  logic                 r_mem_err;

  mem_state_e           r_state;
  mem_state_e           w_state_nxt;

  logic                 w_mem_op;
  logic                 w_load;
  logic                 w_ack;
  logic                 w_expired;
  logic                 w_timeout;
  logic                 w_complete;
  logic                 w_stall;

  assign w_mem_op = is_mem_op(r_m_valid, r_m_rd, r_m_wr);
  assign w_load   = r_m_rd & ~r_m_wr;
  assign w_ack    = w_mem_op & bus.dmem_ack;

  mem_ack_timer #(
    .TIMEOUT (ACK_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (r_state != MEM_WAIT),
    .i_enable  (r_state == MEM_WAIT),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= MEM_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MEM_IDLE: if (w_mem_op && !w_ack) w_state_nxt = MEM_WAIT;
      MEM_WAIT: if (!w_mem_op || w_ack || w_timeout) w_state_nxt = MEM_IDLE;
      default:  w_state_nxt = MEM_IDLE;
    endcase
  end

  // A real ack beats the timeout when both land in the same cycle
  always_comb begin
    w_timeout  = 1'b0;
    if (r_state == MEM_WAIT) w_timeout = w_mem_op & w_expired & ~bus.dmem_ack;
    w_complete = ~w_mem_op | w_ack | w_timeout;
    w_stall    = w_mem_op & ~w_complete;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_rd    <= 1'b0;
      r_m_wr    <= 1'b0;
      r_m_rw    <= 1'b0;
      r_m_halt  <= 1'b0;
      r_m_alu   <= '0;
      r_m_sd    <= '0;
      r_m_dst   <= '0;
    end else if (!w_stall) begin
      r_m_valid <= bus.ex_valid;
      r_m_rd    <= bus.ex_mem_read;
      r_m_wr    <= bus.ex_mem_write;
      r_m_rw    <= bus.ex_reg_write;
      r_m_halt  <= bus.ex_halt;
      r_m_alu   <= bus.ex_alu_result;
      r_m_sd    <= bus.ex_store_data;
      r_m_dst   <= bus.ex_dst_reg;
    end
  end

  // Aborted ops and stall cycles both leave a bubble in W
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_rw    <= 1'b0;
      r_wb_halt  <= 1'b0;
      r_wb_dst   <= '0;
      r_wb_data  <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      if (w_timeout) r_mem_err <= 1'b1;
      if (w_complete && r_m_valid && !w_timeout) begin
        r_wb_valid <= 1'b1;
        r_wb_rw    <= r_m_rw & ~r_m_wr;
        r_wb_halt  <= r_m_halt;
        r_wb_dst   <= r_m_dst;
        r_wb_data  <= w_load ? bus.dmem_rdata : r_m_alu;
      end else begin
        r_wb_valid <= 1'b0;
        r_wb_rw    <= 1'b0;
        r_wb_halt  <= 1'b0;
      end
    end
  end

  assign bus.mem_stall    = w_stall;
  assign bus.dmem_req     = w_mem_op;
  assign bus.dmem_we      = w_mem_op & r_m_wr;
  assign bus.dmem_addr    = r_m_alu;
  assign bus.dmem_wdata   = r_m_sd;

  assign bus.fwd_valid    = r_m_valid & r_m_rw & ~r_m_rd;
  assign bus.fwd_dst      = r_m_dst;
  assign bus.fwd_data     = r_m_alu;

  assign bus.wb_valid     = r_wb_valid;
  assign bus.wb_reg_write = r_wb_rw;
  assign bus.wb_halt      = r_wb_halt;
  assign bus.wb_dst_reg   = r_wb_dst;
  assign bus.wb_data      = r_wb_data;
  assign bus.mem_err      = r_mem_err;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed and randomized checks of mem_stage against a transaction-level model
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  mem_stage_if #(.DATA_W(16)) bus ();

  mem_stage #(.DATA_W(16), .ACK_TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                        input logic rd, input logic wr, input logic rw, input logic halt,
                        input logic [3:0] dst);
    bus.ex_valid      = v;
    bus.ex_alu_result = alu;
    bus.ex_store_data = sd;
    bus.ex_mem_read   = rd;
    bus.ex_mem_write  = wr;
    bus.ex_reg_write  = rw;
    bus.ex_halt       = halt;
    bus.ex_dst_reg    = dst;
  endtask

  task automatic clear_ex();
    set_ex(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    int n;
    logic [15:0] rd_data;
    clear_ex();
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 16'h0;

    // reset: every output zero
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    settle();
    chk("rst_stall", bus.mem_stall, 0);
    chk("rst_req", bus.dmem_req, 0);
    chk("rst_we", bus.dmem_we, 0);
    chk("rst_addr", bus.dmem_addr, 0);
    chk("rst_wdata", bus.dmem_wdata, 0);
    chk("rst_fwd_valid", bus.fwd_valid, 0);
    chk("rst_fwd_dst", bus.fwd_dst, 0);
    chk("rst_fwd_data", bus.fwd_data, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_rw", bus.wb_reg_write, 0);
    chk("rst_wb_halt", bus.wb_halt, 0);
    chk("rst_wb_dst", bus.wb_dst_reg, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_mem_err", bus.mem_err, 0);

    // ALU op: two edges to W, no stall
    set_ex(1, 16'h1234, 16'h0, 0, 0, 1, 0, 4'd3);
    tick(); clear_ex(); settle();
    chk("alu_stall_m", bus.mem_stall, 0);
    chk("alu_wb_valid_early", bus.wb_valid, 0);
    tick(); settle();
    chk("alu_wb_valid", bus.wb_valid, 1);
    chk("alu_wb_data", bus.wb_data, 16'h1234);
    chk("alu_wb_dst", bus.wb_dst_reg, 3);
    chk("alu_wb_rw", bus.wb_reg_write, 1);
    chk("alu_stall_w", bus.mem_stall, 0);

    // forwarding from ALU write vs load
    set_ex(1, 16'h0777, 16'h0, 0, 0, 1, 0, 4'd5);
    tick(); clear_ex(); settle();
    chk("fwd_alu_valid", bus.fwd_valid, 1);
    chk("fwd_alu_dst", bus.fwd_dst, 5);
    chk("fwd_alu_data", bus.fwd_data, 16'h0777);
    tick();

    // zero-wait load
    set_ex(1, 16'h0040, 16'h0, 1, 0, 1, 0, 4'd5);
    tick(); clear_ex();
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 16'hBEEF;
    settle();
    chk("zl_fwd_valid", bus.fwd_valid, 0);
    chk("zl_req", bus.dmem_req, 1);
    chk("zl_we", bus.dmem_we, 0);
    chk("zl_addr", bus.dmem_addr, 16'h0040);
    chk("zl_stall", bus.mem_stall, 0);
    tick(); bus.dmem_ack = 1'b0; settle();
    chk("zl_wb_valid", bus.wb_valid, 1);
    chk("zl_wb_data", bus.wb_data, 16'hBEEF);
    chk("zl_wb_dst", bus.wb_dst_reg, 5);

    // three-wait store, reg_write requested but must be suppressed
    set_ex(1, 16'h0100, 16'h00AA, 0, 1, 1, 0, 4'd6);
    tick(); clear_ex();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      bus.dmem_ack = (i == 3);
      settle();
      chk("st3_req", bus.dmem_req, 1);
      chk("st3_we", bus.dmem_we, 1);
      chk("st3_addr", bus.dmem_addr, 16'h0100);
      chk("st3_wdata", bus.dmem_wdata, 16'h00AA);
      if (bus.mem_stall) n++;
      tick();
    end
    bus.dmem_ack = 1'b0; settle();
    chk("st3_stall_cycles", n, 3);
    chk("st3_wb_valid", bus.wb_valid, 1);
    chk("st3_wb_rw", bus.wb_reg_write, 0);
    chk("st3_req_after", bus.dmem_req, 0);

    // timeout abort
    set_ex(1, 16'h0200, 16'h0, 1, 0, 1, 0, 4'd4);
    tick(); clear_ex();
    n = 0;
    settle();
    while (bus.mem_stall && n < 400) begin
      n++;
      if (bus.mem_err !== 1'b0) break;
      tick();
    end
    chk("to_stall_cycles", n, 255);
    chk("to_req_abort_cycle", bus.dmem_req, 1);
    tick(); settle();
    chk("to_mem_err", bus.mem_err, 1);
    chk("to_wb_valid", bus.wb_valid, 0);
    chk("to_stall_after", bus.mem_stall, 0);
    set_ex(1, 16'h0011, 16'h0, 0, 0, 1, 0, 4'd1);
    tick(); clear_ex(); tick(); settle();
    chk("to_err_sticky", bus.mem_err, 1);
    chk("to_next_wb_valid", bus.wb_valid, 1);

    // reset during WAIT, late ack ignored
    set_ex(1, 16'h0300, 16'h0, 1, 0, 1, 0, 4'd2);
    tick(); clear_ex(); tick(); settle();
    chk("rw_in_wait_stall", bus.mem_stall, 1);
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; settle();
    chk("rw_req", bus.dmem_req, 0);
    chk("rw_wb_valid", bus.wb_valid, 0);
    chk("rw_fwd_valid", bus.fwd_valid, 0);
    chk("rw_mem_err", bus.mem_err, 0);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 16'hDEAD;
    settle();
    chk("rw_stall", bus.mem_stall, 0);
    tick(); bus.dmem_ack = 1'b0; settle();
    chk("rw_late_ack_wb", bus.wb_valid, 0);
    tick(); settle();
    chk("rw_late_ack_wb2", bus.wb_valid, 0);

    // read+write conflict: store wins
    set_ex(1, 16'h0400, 16'h0055, 1, 1, 1, 0, 4'd7);
    tick(); clear_ex();
    bus.dmem_ack = 1'b1; settle();
    chk("rwc_we", bus.dmem_we, 1);
    chk("rwc_wdata", bus.dmem_wdata, 16'h0055);
    chk("rwc_fwd_valid", bus.fwd_valid, 0);
    tick(); bus.dmem_ack = 1'b0; settle();
    chk("rwc_wb_valid", bus.wb_valid, 1);
    chk("rwc_wb_rw", bus.wb_reg_write, 0);

    // back-to-back store then load, load held in execute while stalled
    set_ex(1, 16'h0500, 16'h1111, 0, 1, 0, 0, 4'd0);
    tick();
    set_ex(1, 16'h0600, 16'h0, 1, 0, 1, 1, 4'd9);
    settle();
    chk("b2b_stall1", bus.mem_stall, 1);
    chk("b2b_addr1", bus.dmem_addr, 16'h0500);
    tick();
    bus.dmem_ack = 1'b1; settle();
    chk("b2b_addr1_hold", bus.dmem_addr, 16'h0500);
    chk("b2b_stall1_end", bus.mem_stall, 0);
    tick(); clear_ex();
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 16'h4242; settle();
    chk("b2b_req2", bus.dmem_req, 1);
    chk("b2b_addr2", bus.dmem_addr, 16'h0600);
    chk("b2b_wb_store", bus.wb_valid, 1);
    tick(); bus.dmem_ack = 1'b0; settle();
    chk("b2b_wb_data2", bus.wb_data, 16'h4242);
    chk("b2b_wb_halt2", bus.wb_halt, 1);
    chk("b2b_wb_dst2", bus.wb_dst_reg, 9);

    // randomized single-issue ops against the behavioural model
    for (int t = 0; t < 60; t++) begin
      logic        r_rd, r_wr, r_rw, r_halt;
      logic [15:0] r_alu, r_sd;
      logic [3:0]  r_dst;
      int          k;
      r_rd   = 1'($urandom); r_wr = 1'($urandom);
      r_rw   = 1'($urandom); r_halt = 1'($urandom);
      r_alu  = 16'($urandom); r_sd = 16'($urandom);
      r_dst  = 4'($urandom);
      k      = $urandom_range(0, 3);
      rd_data = 16'($urandom);
      // unsolicited ack in an empty cycle must leave no trace
      bus.dmem_ack = 1'($urandom);
      tick(); bus.dmem_ack = 1'b0; settle();
      chk("rnd_idle_wb", bus.wb_valid, 0);
      set_ex(1, r_alu, r_sd, r_rd, r_wr, r_rw, r_halt, r_dst);
      tick(); clear_ex(); settle();
      chk("rnd_fwd_valid", bus.fwd_valid, r_rw & ~r_rd);
      if (r_rd | r_wr) begin
        for (int i = 0; i <= k; i++) begin
          bus.dmem_ack = (i == k);
          bus.dmem_rdata = (i == k) ? rd_data : 16'($urandom);
          settle();
          chk("rnd_stall", bus.mem_stall, (i < k));
          chk("rnd_req", bus.dmem_req, 1);
          chk("rnd_we", bus.dmem_we, r_wr);
          chk("rnd_addr", bus.dmem_addr, r_alu);
          tick();
        end
        bus.dmem_ack = 1'b0;
      end else begin
        chk("rnd_alu_stall", bus.mem_stall, 0);
        chk("rnd_alu_req", bus.dmem_req, 0);
        tick();
      end
      settle();
      chk("rnd_wb_valid", bus.wb_valid, 1);
      chk("rnd_wb_rw", bus.wb_reg_write, r_rw & ~r_wr);
      chk("rnd_wb_halt", bus.wb_halt, r_halt);
      chk("rnd_wb_dst", bus.wb_dst_reg, r_dst);
      chk("rnd_wb_data", bus.wb_data, (r_rd & ~r_wr) ? rd_data : r_alu);
    end
    chk("rnd_mem_err_clear", bus.mem_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 16-bit pipelined core, directly downstream of the execute stage. It holds the EX/MEM pipeline register and drives the data-memory request/acknowledge handshake for loads and stores. While an access is outstanding it stalls the front of the pipeline. It produces the MEM/WB register contents and the forwarding value returned to execute.

## Interface
- `DATA_W`, 16, datapath and address width.
- `ACK_TIMEOUT`, 255, maximum cycles an access may wait for `dmem_ack` before it is aborted.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `ex_valid`  in  1  execute stage holds a live instruction.
- `ex_alu_result`  in  DATA_W  ALU result; used as the address for memory ops.
- `ex_store_data`  in  DATA_W  second register operand; used as store data.
- `ex_mem_read`, `ex_mem_write`, `ex_reg_write`, `ex_halt`  in  1 each  control bits.
- `ex_dst_reg`  in  4  destination register index.
- `mem_stall`  out  1  freezes PC, IF/ID and ID/EX while high.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`, `dmem_wdata`  out  DATA_W  request address and store data.
- `dmem_rdata`  in  DATA_W  load data; valid in the cycle `dmem_ack` is high.
- `dmem_ack`  in  1  access complete.
- `fwd_valid`  out  1  M-register holds a non-load register write.
- `fwd_dst`  out  4  forwarding destination register.
- `fwd_data`  out  DATA_W  forwarding value.
- `wb_valid`, `wb_reg_write`, `wb_halt`  out  1 each  MEM/WB register bits.
- `wb_dst_reg`  out  4  MEM/WB destination register.
- `wb_data`  out  DATA_W  MEM/WB write-back value.
- `mem_err`  out  1  sticky; set when an access times out.

## Operation
- **M-register.** Captures all `ex_*` inputs on each edge where `mem_stall` = 0. It captures `valid` = `ex_valid`, so a capture with `ex_valid` low inserts a bubble. It holds its contents while stalled.
- **Memory ops.**
  - An instruction is a memory op when M is valid and `mem_read` or `mem_write` is set.
  - If both bits are set, the store wins and `wb_reg_write` is forced to 0.
- **FSM state IDLE.**
  - With a memory op in M: `dmem_req` = 1; `dmem_addr`, `dmem_wdata` and `dmem_we` come from the M-register.
  - If `dmem_ack` is high in the same cycle, the op completes in that cycle. Otherwise the FSM moves to WAIT.
- **FSM state WAIT.**
  - `dmem_req` stays high with address and data held stable.
  - The 8-bit timer increments every cycle.
  - On `dmem_ack`, the op completes and the FSM returns to IDLE.
  - When the timer reaches `ACK_TIMEOUT`, the op completes as aborted: `mem_err` is set, `wb_valid` is 0 for that op, and the FSM returns to IDLE.
- **Stall.** `mem_stall` = (memory op in M) AND NOT (completing this cycle). It is combinational, so a zero-wait memory causes no stall.
- **W-register.**
  - Loads from M on each edge where M completes. Non-memory ops complete immediately.
  - `wb_data` = `dmem_rdata` for loads and the ALU result otherwise.
  - If M does not complete on an edge, W loads a bubble (`wb_valid` = 0).
- **Forwarding.** `fwd_*` reflects the M-register combinationally. `fwd_valid` = M valid AND `reg_write` AND NOT `mem_read`.
- **Unsolicited ack.** `dmem_ack` while `dmem_req` = 0 is ignored.

## Timing
- **Reset.** Clears M and W valid bits and `mem_err`, puts the FSM in IDLE and zeroes the timer. After the reset edge, every output is 0.
- **Non-memory op:** latency is 2 edges from execute (edge into M, edge into W).
- **Load or store:** W is updated on the edge ending the `dmem_ack` cycle. With a k-cycle wait, latency is 2 + k edges and `mem_stall` is high for k cycles.
- **Reset during WAIT.** `dmem_req` drops after that edge. No write-back occurs, and a late ack is ignored.
- **Back-to-back memory ops** each take at least one request cycle. `dmem_req` may stay high across the boundary while the address changes.

## Structure
- The shared defines file holds the FSM state encodings (`MEM_IDLE`, `MEM_WAIT`) and the register-index width.
- The timeout counter is the sub-module `mem_ack_timer`: inputs clear and enable, output expired.

## Test plan
- **ALU op:** ADD result 0x1234 to r3 with no memory bits → two edges later `wb_valid` = 1, `wb_data` = 0x1234, `wb_dst_reg` = 3; `mem_stall` never rises.
- **Zero-wait load:** addr 0x0040 with `dmem_ack` in the same cycle, `rdata` = 0xBEEF → `mem_stall` stays 0; `wb_data` = 0xBEEF on the next edge.
- **Three-wait store:** addr 0x0100, data 0x00AA → `dmem_req`/`dmem_we` high for 4 cycles with address and data stable; `mem_stall` high for 3 cycles; `wb_reg_write` = 0.
- **Timeout:** load with no ack → abort after 255 WAIT cycles; `mem_err` = 1 and stays 1; `wb_valid` = 0; `mem_stall` falls.
- **Reset in WAIT:** `rst_n` low during WAIT → next edge `dmem_req` = 0 and all valid bits = 0; a following `dmem_ack` causes no write-back.
- **Forwarding and read/write conflict:**
  - An ALU write to r5 in M → `fwd_valid` = 1, `fwd_dst` = 5; a load to r5 → `fwd_valid` = 0.
  - An op with both `mem_read` and `mem_write` set → performs a store, and `wb_reg_write` = 0.
